traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Phase controller for the junction: main road vs. side road.
//   - Initiator side of the Timer interface: drives Value and Start_Timer, advances on Expired.
//   - Steps the lamps through green/yellow/all-red phases and extends main green until a side-road
//     (or pedestrian) request is latched.
// PARAMETERS
//   MAIN_GREEN   9  main-road green duration, seconds (1..15)
//   MAIN_YELLOW  3  main-road yellow duration, seconds (1..15)
//   SIDE_GREEN   6  side-road green duration, seconds (1..15)
//   SIDE_YELLOW  3  side-road yellow duration, seconds (1..15)
//   ALL_RED      1  all-red clearance duration, seconds (1..15)
//   WALK_TIME    5  pedestrian walk duration, seconds (1..15); used only with PED_WALK_EN
// PORTS
//   clk           in   1  system clock
//   Sync_Reset    in   1  reset, asynchronous, active-high
//   Expired       in   1  timer expiry pulse from Timer
//   Sensor        in   1  side-road vehicle present, level, synchronous to clk
//   Walk_Request  in   1  pedestrian button, level; port exists only with PED_WALK_EN
//   Value         out  4  duration of the current phase, to Timer
//   Start_Timer   out  1  one-cycle start pulse, to Timer
//   Main_Light    out  3  {R,Y,G} main road, active-high, exactly one bit set
//   Side_Light    out  3  {R,Y,G} side road, active-high, exactly one bit set
//   Walk          out  1  pedestrian walk lamp; constant 0 without PED_WALK_EN
//   Phase         out  3  current state encoding, for debug/display
// BEHAVIOUR
//   Reset (async, while Sync_Reset=1):
//     - state=MAIN_G, sub-phase=ARM; Value=MAIN_GREEN; Start_Timer=0
//     - Main_Light=3'b001, Side_Light=3'b100, Walk=0; request latches cleared
//   Every phase has two sub-phases:
//     - ARM: exactly one cycle; Start_Timer=1; Value already holds the new phase duration.
//     - WAIT: Start_Timer=0; Value held stable. Expired is sampled only here.
//     - Expired seen in ARM is ignored; this absorbs stale pulses after reset or a phase change.
//   Expired=1 in WAIT: take the transition, register the new state, enter ARM on the next cycle.
//   Lamps and Value are registered and change in the same cycle as the state.
//   Lamp outputs are a pure decode of the state, so exactly one bit of each lamp bus is set.
//   States, Phase code, lamps (Main/Side) and transitions:
//     MAIN_G 0 G/R : Expired & (side_req | walk_req) -> MAIN_Y; Expired & no request -> MAIN_G
//                    (re-ARM with MAIN_GREEN)
//     MAIN_Y 1 Y/R : Expired -> RED_A
//     RED_A  2 R/R : Expired & side_req -> SIDE_G; else if walk_req -> WALK; else -> MAIN_G
//     SIDE_G 3 R/G : Expired -> SIDE_Y
//     SIDE_Y 4 R/Y : Expired -> RED_B
//     RED_B  5 R/R : Expired & walk_req -> WALK; else -> MAIN_G
//     WALK   6 R/R : Walk=1; Expired -> RED_B
//     Codes 7 and any illegal state -> MAIN_G/ARM next cycle.
//   Value per state:
//     - MAIN_G=MAIN_GREEN, MAIN_Y=MAIN_YELLOW, RED_A/RED_B=ALL_RED
//     - SIDE_G=SIDE_GREEN, SIDE_Y=SIDE_YELLOW, WALK=WALK_TIME
//   side_req:
//     - set on any cycle with Sensor=1
//     - cleared on the ARM cycle of SIDE_G
//     - set and clear in the same cycle -> set wins
//   walk_req: same set/clear rules, using Walk_Request and the ARM cycle of WALK.
//   Reset mid-phase: immediate return to the reset values; Start_Timer is not asserted during reset.
//   Parameters outside 1..15 -> elaboration error (generate-time check).
// CONFIGURATION
//   PED_WALK_EN defined:
//     - Walk_Request port, walk_req latch and the WALK state are present.
//   PED_WALK_EN undefined:
//     - no Walk_Request port; walk_req is tied 0 and the WALK state is unreachable.
//     - Walk is tied 0.
//     - The remaining transitions are unchanged.
// TESTING
//   1. Reset -> Main_Light=001, Side_Light=100, Value=9; Start_Timer pulses once on the 1st clk after release.
//   2. Sensor=0, Expired pulses -> stays MAIN_G; Start_Timer re-pulses; Value stays 9.
//   3. Sensor pulse 1 cycle, then Expired -> state sequence MAIN_Y(3), RED_A(1), SIDE_G(6), SIDE_Y(3),
//      RED_B(1), MAIN_G(9); Value/lamps change per phase; one Start_Timer per phase.
//   4. Expired held high across ARM -> no transition until the first WAIT-cycle Expired.
//   5. Sync_Reset asserted during SIDE_G -> outputs return to reset values asynchronously; side_req cleared.
//   6. PED_WALK_EN: Walk_Request only, Expired in MAIN_G -> MAIN_Y, RED_A, WALK (Walk=1, Value=5),
//      RED_B, MAIN_G.

Source files
------------

// File: rtl/traffic_phase_sequencer_if.sv
// Timer handshake between the phase sequencer (master) and the phase timer (slave).
interface traffic_phase_sequencer_if;
  logic [3:0] Value;
  logic       Start_Timer;
  logic       Expired;

  modport master (output Value, output Start_Timer, input Expired);
  modport slave  (input Value, input Start_Timer, output Expired);
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Junction phase controller: main/side green-yellow-all-red cycle driven by an external timer.
// Optional pedestrian walk phase is compiled in when PED_WALK_EN is defined.
module traffic_phase_sequencer #(
  parameter int MAIN_GREEN  = 9,
  parameter int MAIN_YELLOW = 3,
  parameter int SIDE_GREEN  = 6,
  parameter int SIDE_YELLOW = 3,
  parameter int ALL_RED     = 1,
  parameter int WALK_TIME   = 5
) (
  input  logic                        clk,
  input  logic                        Sync_Reset,
  traffic_phase_sequencer_if.master   timer,
  input  logic                        Sensor,
`ifdef PED_WALK_EN
  input  logic                        Walk_Request,
`endif
  output logic [2:0]                  Main_Light,
  output logic [2:0]                  Side_Light,
  output logic                        Walk,
  output logic [2:0]                  Phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    WALK   = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [191:0] DURS = {32'(MAIN_GREEN), 32'(MAIN_YELLOW), 32'(SIDE_GREEN),
                                   32'(SIDE_YELLOW), 32'(ALL_RED), 32'(WALK_TIME)};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_range_check
      if (($signed(DURS[gi*32 +: 32]) < 1) || ($signed(DURS[gi*32 +: 32]) > 15)) begin : g_bad
        $error("traffic_phase_sequencer: phase duration %0d outside 1..15",
               $signed(DURS[gi*32 +: 32]));
      end
    end
  endgenerate

  state_t     state_reg, state_next;
  // arm_reg=1 with start_reg=0 only right after reset: the ARM pulse is issued one cycle later
  logic       arm_reg, arm_next;
  logic       start_reg, start_next;
  logic [3:0] value_reg, value_next;
  logic [2:0] main_light_reg, main_light_next;
  logic [2:0] side_light_reg, side_light_next;
  logic       side_req_reg, side_req_next;
  logic       walk_req;

  logic arming;
  assign arming = arm_reg & start_reg;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      state_reg      <= MAIN_G;
      arm_reg        <= 1'b1;
      start_reg      <= 1'b0;
      value_reg      <= 4'(MAIN_GREEN);
      main_light_reg <= LAMP_G;
      side_light_reg <= LAMP_R;
      side_req_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      arm_reg        <= arm_next;
      start_reg      <= start_next;
      value_reg      <= value_next;
      main_light_reg <= main_light_next;
      side_light_reg <= side_light_next;
      side_req_reg   <= side_req_next;
    end
  end

  // Request latches: a new request in the clearing cycle wins
  assign side_req_next = Sensor | (side_req_reg & ~(arming && state_reg == SIDE_G));

`ifdef PED_WALK_EN
  logic walk_req_reg, walk_req_next;
  logic walk_lamp_reg, walk_lamp_next;

  assign walk_req_next = Walk_Request | (walk_req_reg & ~(arming && state_reg == WALK));
  assign walk_req      = walk_req_reg;

  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      walk_req_reg  <= 1'b0;
      walk_lamp_reg <= 1'b0;
    end else begin
      walk_req_reg  <= walk_req_next;
      walk_lamp_reg <= walk_lamp_next;
    end
  end

  assign Walk = walk_lamp_reg;
`else
  assign walk_req = 1'b0;
  assign Walk     = 1'b0;
`endif

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    arm_next   = arm_reg;
    start_next = 1'b0;
    if (state_reg == 3'd7) begin
      state_next = MAIN_G;
      arm_next   = 1'b1;
      start_next = 1'b1;
    end else if (arm_reg) begin
      // Expired is deliberately ignored while arming
      if (start_reg) begin
        arm_next = 1'b0;
      end else begin
        start_next = 1'b1;
      end
    end else if (timer.Expired) begin
      arm_next   = 1'b1;
      start_next = 1'b1;
      case (state_reg)
        MAIN_G:  state_next = (side_req_reg | walk_req) ? MAIN_Y : MAIN_G;
        MAIN_Y:  state_next = RED_A;
        RED_A: begin
          if (side_req_reg)  state_next = SIDE_G;
          else if (walk_req) state_next = WALK;
          else               state_next = MAIN_G;
        end
        SIDE_G:  state_next = SIDE_Y;
        SIDE_Y:  state_next = RED_B;
        RED_B:   state_next = walk_req ? WALK : MAIN_G;
        WALK:    state_next = RED_B;
        default: state_next = MAIN_G;
      endcase
    end
  end

  // ---------------- output decode (registered alongside the state) ----------------
  always_comb begin
    value_next      = 4'(MAIN_GREEN);
    main_light_next = LAMP_R;
    side_light_next = LAMP_R;
    case (state_next)
      MAIN_G: begin
        value_next      = 4'(MAIN_GREEN);
        main_light_next = LAMP_G;
      end
      MAIN_Y: begin
        value_next      = 4'(MAIN_YELLOW);
        main_light_next = LAMP_Y;
      end
      RED_A, RED_B: value_next = 4'(ALL_RED);
      SIDE_G: begin
        value_next      = 4'(SIDE_GREEN);
        side_light_next = LAMP_G;
      end
      SIDE_Y: begin
        value_next      = 4'(SIDE_YELLOW);
        side_light_next = LAMP_Y;
      end
      WALK:   value_next = 4'(WALK_TIME);
      default: begin
        value_next      = 4'(MAIN_GREEN);
        main_light_next = LAMP_G;
      end
    endcase
  end

`ifdef PED_WALK_EN
  assign walk_lamp_next = (state_next == WALK);
`endif

  assign timer.Value       = value_reg;
  assign timer.Start_Timer = start_reg;
  assign Main_Light        = main_light_reg;
  assign Side_Light        = side_light_reg;
  assign Phase             = state_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer; the bench plays the timer by driving Expired.
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       sensor;
  logic       walk_request;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  traffic_phase_sequencer_if tif ();

  traffic_phase_sequencer dut (
    .clk        (clk),
    .Sync_Reset (rst),
    .timer      (tif),
    .Sensor     (sensor),
`ifdef PED_WALK_EN
    .Walk_Request (walk_request),
`endif
    .Main_Light (main_light),
    .Side_Light (side_light),
    .Walk       (walk),
    .Phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    $display("check %-14s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Check a freshly armed phase: code, duration, lamps and the start pulse
  task automatic chk_phase(input string tag, input logic [2:0] p, input logic [3:0] v,
                           input logic [2:0] m, input logic [2:0] s);
    chk({tag, ".phase"}, 32'(phase), 32'(p));
    chk({tag, ".value"}, 32'(tif.Value), 32'(v));
    chk({tag, ".main"},  32'(main_light), 32'(m));
    chk({tag, ".side"},  32'(side_light), 32'(s));
    chk({tag, ".start"}, 32'(tif.Start_Timer), 32'd1);
  endtask

  // One-cycle Expired from a WAIT cycle; returns in the new phase's ARM cycle
  task automatic expire();
    tif.Expired = 1'b1;
    tick();
    tif.Expired = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sensor       = 1'b0;
    walk_request = 1'b0;
    tif.Expired  = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst.main",  32'(main_light), 32'h1);
    chk("rst.side",  32'(side_light), 32'h4);
    chk("rst.value", 32'(tif.Value), 32'd9);
    chk("rst.start", 32'(tif.Start_Timer), 32'd0);
    chk("rst.phase", 32'(phase), 32'd0);
    chk("rst.walk",  32'(walk), 32'd0);

    // Expired during reset must be absorbed
    tif.Expired = 1'b1;
    tick();
    tif.Expired = 1'b0;
    rst = 1'b0;
    tick();
    chk("arm0.start", 32'(tif.Start_Timer), 32'd1);
    chk("arm0.phase", 32'(phase), 32'd0);
    tick();
    chk("wait0.start", 32'(tif.Start_Timer), 32'd0);
    tick();
    chk("wait0b.start", 32'(tif.Start_Timer), 32'd0);

    // No request: MAIN_G re-arms
    expire();
    chk_phase("rearm", 3'd0, 4'd9, 3'b001, 3'b100);
    tick();
    chk("rearm.wait", 32'(tif.Start_Timer), 32'd0);

    // One-cycle sensor pulse then the full side cycle
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    tick();
    expire(); chk_phase("main_y", 3'd1, 4'd3, 3'b010, 3'b100); tick();
    expire(); chk_phase("red_a",  3'd2, 4'd1, 3'b100, 3'b100); tick();
    expire(); chk_phase("side_g", 3'd3, 4'd6, 3'b100, 3'b001); tick();
    chk("side_g.wait", 32'(tif.Start_Timer), 32'd0);
    expire(); chk_phase("side_y", 3'd4, 4'd3, 3'b100, 3'b010); tick();
    expire(); chk_phase("red_b",  3'd5, 4'd1, 3'b100, 3'b100); tick();
    expire(); chk_phase("main_g", 3'd0, 4'd9, 3'b001, 3'b100); tick();

    // Request was consumed by SIDE_G: main green extends
    expire();
    chk("noreq.phase", 32'(phase), 32'd0);
    tick();

    // Expired held high across ARM
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    tif.Expired = 1'b1;
    tick();
    chk("hold.a.phase", 32'(phase), 32'd1);
    chk("hold.a.start", 32'(tif.Start_Timer), 32'd1);
    tick();
    chk("hold.b.phase", 32'(phase), 32'd1);
    chk("hold.b.start", 32'(tif.Start_Timer), 32'd0);
    tick();
    chk("hold.c.phase", 32'(phase), 32'd2);
    tif.Expired = 1'b0;
    tick();

    // Reset asserted in the middle of SIDE_G with a fresh request pending
    expire();
    chk("sg.phase", 32'(phase), 32'd3);
    tick();
    sensor = 1'b1;
    tick();
    sensor = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.main",  32'(main_light), 32'h1);
    chk("arst.side",  32'(side_light), 32'h4);
    chk("arst.value", 32'(tif.Value), 32'd9);
    chk("arst.phase", 32'(phase), 32'd0);
    chk("arst.start", 32'(tif.Start_Timer), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst.arm", 32'(tif.Start_Timer), 32'd1);
    tick();
    expire();
    chk("arst.noreq", 32'(phase), 32'd0);
    tick();

`ifdef PED_WALK_EN
    // Pedestrian-only request
    walk_request = 1'b1;
    tick();
    walk_request = 1'b0;
    tick();
    expire(); chk_phase("w.main_y", 3'd1, 4'd3, 3'b010, 3'b100); tick();
    expire(); chk_phase("w.red_a",  3'd2, 4'd1, 3'b100, 3'b100); tick();
    expire(); chk_phase("w.walk",   3'd6, 4'd5, 3'b100, 3'b100);
    chk("w.walk.lamp", 32'(walk), 32'd1);
    tick();
    expire(); chk_phase("w.red_b",  3'd5, 4'd1, 3'b100, 3'b100);
    chk("w.red_b.lamp", 32'(walk), 32'd0);
    tick();
    expire(); chk_phase("w.main_g", 3'd0, 4'd9, 3'b001, 3'b100); tick();
`else
    chk("walk.tied", 32'(walk), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
